// File: rtl/cal_weekday_resolver.sv
// Resolves (month, date) to weekday and day-of-year by walking prior months one per cycle.
// Seeds the calendar day register from a set date; start/busy/done handshake.
module cal_weekday_resolver #(
   parameter int unsigned LEAP = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] anchor_day,
   input  logic [3:0] month,
   input  logic [4:0] date,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] day_out,
   output logic [8:0] doy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_FIN,
      S_ERR
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_month, w_month_nxt;
   logic [4:0]  r_date, w_date_nxt;
   logic [3:0]  r_idx, w_idx_nxt;
   logic [8:0]  r_acc_doy, w_acc_doy_nxt;
   logic [2:0]  r_acc_wd, w_acc_wd_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic        r_err, w_err_nxt;
   logic [2:0]  r_day, w_day_nxt;
   logic [8:0]  r_doy, w_doy_nxt;

   logic [4:0]  w_len_in;
   logic        w_req_ok;
   logic [2:0]  w_anchor;
   logic [5:0]  w_acc_sum;
   logic [5:0]  w_fin_sum;

   function automatic logic [4:0] f_len(input logic [3:0] m);
      case (m)
         4'd1:                    f_len = (LEAP != 0) ? 5'd29 : 5'd28;
         4'd3, 4'd5, 4'd8, 4'd10: f_len = 5'd30;
         default:                 f_len = 5'd31;
      endcase
   endfunction

   function automatic logic [2:0] f_len_mod7(input logic [3:0] m);
      case (m)
         4'd1:                    f_len_mod7 = (LEAP != 0) ? 3'd1 : 3'd0;
         4'd3, 4'd5, 4'd8, 4'd10: f_len_mod7 = 3'd2;
         default:                 f_len_mod7 = 3'd3;
      endcase
   endfunction

   // Input never exceeds 36, so three compare/subtract stages bring it into 0..6.
   function automatic logic [2:0] f_mod7(input logic [5:0] s);
      logic [5:0] t;
      t = s;
      if (t >= 6'd28) t = t - 6'd28;
      if (t >= 6'd14) t = t - 6'd14;
      if (t >= 6'd7)  t = t - 6'd7;
      f_mod7 = t[2:0];
   endfunction

   assign w_len_in  = f_len(month);
   assign w_req_ok  = (month <= 4'd11) && (date < w_len_in);
   assign w_anchor  = (anchor_day == 3'd7) ? 3'd0 : anchor_day;
   assign w_acc_sum = {3'b000, r_acc_wd} + {3'b000, f_len_mod7(r_idx)};
   assign w_fin_sum = {3'b000, r_acc_wd} + {1'b0, r_date};

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_month_nxt   = r_month;
      w_date_nxt    = r_date;
      w_idx_nxt     = r_idx;
      w_acc_doy_nxt = r_acc_doy;
      w_acc_wd_nxt  = r_acc_wd;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_err_nxt     = r_err;
      w_day_nxt     = r_day;
      w_doy_nxt     = r_doy;

      case (r_state)
         S_IDLE: begin
            // The done cycle itself still counts as the tail of the previous request.
            if (start && !r_done) begin
               w_month_nxt   = month;
               w_date_nxt    = date;
               w_idx_nxt     = 4'd0;
               w_acc_doy_nxt = 9'd0;
               w_acc_wd_nxt  = w_anchor;
               w_err_nxt     = 1'b0;
               w_busy_nxt    = 1'b1;
               if (!w_req_ok)           w_state_nxt = S_ERR;
               else if (month == 4'd0)  w_state_nxt = S_FIN;
               else                     w_state_nxt = S_ACC;
            end
         end
         S_ACC: begin
            w_acc_doy_nxt = r_acc_doy + 9'(f_len(r_idx));
            w_acc_wd_nxt  = f_mod7(w_acc_sum);
            w_idx_nxt     = r_idx + 4'd1;
            if (r_idx + 4'd1 == r_month) w_state_nxt = S_FIN;
         end
         S_FIN: begin
            w_doy_nxt   = r_acc_doy + 9'(r_date);
            w_day_nxt   = f_mod7(w_fin_sum);
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         S_ERR: begin
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_month   <= 4'd0;
         r_date    <= 5'd0;
         r_idx     <= 4'd0;
         r_acc_doy <= 9'd0;
         r_acc_wd  <= 3'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_day     <= 3'd0;
         r_doy     <= 9'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_month   <= w_month_nxt;
         r_date    <= w_date_nxt;
         r_idx     <= w_idx_nxt;
         r_acc_doy <= w_acc_doy_nxt;
         r_acc_wd  <= w_acc_wd_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_day     <= w_day_nxt;
         r_doy     <= w_doy_nxt;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;
   assign day_out = r_day;
   assign doy     = r_doy;

endmodule

// File: tb/tb_cal_weekday_resolver.sv
// Scoreboard bench: a common-year and a leap-year resolver share stimulus; a monitor
// pops hand-computed expectations (including done cycle) whenever a done pulse appears.
module tb_cal_weekday_resolver;

   typedef struct {
      logic       err;
      logic [2:0] day;
      logic [8:0] doy;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] anchor_day;
   logic [3:0] month;
   logic [4:0] date;
   logic       busy0, done0, err0, busy1, done1, err1;
   logic [2:0] day0, day1;
   logic [8:0] doy0, doy1;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   cal_weekday_resolver #(.LEAP(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .anchor_day(anchor_day), .month(month),
      .date(date), .busy(busy0), .done(done0), .err(err0), .day_out(day0), .doy(doy0)
   );

   cal_weekday_resolver #(.LEAP(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .anchor_day(anchor_day), .month(month),
      .date(date), .busy(busy1), .done(done1), .err(err1), .day_out(day1), .doy(doy1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done0) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL d0_unexpected_done actual=1 required=0 cyc=%0d", cyc);
         end else begin
            e0 = q0.pop_front();
            chk("d0_err", 32'(err0), 32'(e0.err));
            chk("d0_day", 32'(day0), 32'(e0.day));
            chk("d0_doy", 32'(doy0), 32'(e0.doy));
            chk("d0_done_cycle", 32'(cyc), 32'(e0.cyc));
         end
      end
      if (done1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL d1_unexpected_done actual=1 required=0 cyc=%0d", cyc);
         end else begin
            e1 = q1.pop_front();
            chk("d1_err", 32'(err1), 32'(e1.err));
            chk("d1_day", 32'(day1), 32'(e1.day));
            chk("d1_doy", 32'(doy1), 32'(e1.doy));
            chk("d1_done_cycle", 32'(cyc), 32'(e1.cyc));
         end
      end
   end

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy0 && !busy1 && !done0 && !done1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=busy required=idle", name);
      end
   endtask

   // Issue one request; expectation per instance is (err, weekday, doy, latency).
   // poke=1 adds a start two cycles into the walk and another on the done cycle.
   task automatic run_vec(input string name, input logic [2:0] a, input logic [3:0] m,
                          input logic [4:0] d,
                          input logic x0, input logic [2:0] w0, input logic [8:0] y0, input int l0,
                          input logic x1, input logic [2:0] w1, input logic [8:0] y1, input int l1,
                          input bit poke);
      exp_t t;
      bit   seen;
      @(negedge clk);
      anchor_day = a; month = m; date = d; start = 1'b1;
      t.err = x0; t.day = w0; t.doy = y0; t.cyc = cyc + 1 + l0; q0.push_back(t);
      t.err = x1; t.day = w1; t.doy = y1; t.cyc = cyc + 1 + l1; q1.push_back(t);
      @(negedge clk);
      start = 1'b0;
      anchor_day = 3'($urandom); month = 4'($urandom); date = 5'($urandom);
      if (poke) begin
         @(negedge clk);
         start = 1'b1; month = 4'd0; date = 5'd0;
         @(negedge clk);
         start = 1'b0;
         seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (done0) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout actual=0 required=1", name);
         end
         start = 1'b1; anchor_day = 3'd1; month = 4'd0; date = 5'd1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle(name);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; anchor_day = 3'd0; month = 4'd0; date = 5'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_err", 32'(err0), 0);
      chk("rst_day", 32'(day0), 0);
      chk("rst_doy", 32'(doy1), 0);
      rst = 1'b0;
      @(negedge clk);

      run_vec("jan1",    3'd0, 4'd0,  5'd0,  0, 3'd0, 9'd0,   1, 0, 3'd0, 9'd0,   1, 0);
      run_vec("jan31",   3'd6, 4'd0,  5'd30, 0, 3'd1, 9'd30,  1, 0, 3'd1, 9'd30,  1, 0);
      run_vec("dec31",   3'd3, 4'd11, 5'd30, 0, 3'd3, 9'd364, 12, 0, 3'd4, 9'd365, 12, 0);
      run_vec("mar1",    3'd0, 4'd2,  5'd0,  0, 3'd3, 9'd59,  3, 0, 3'd4, 9'd60,  3, 0);
      run_vec("feb29",   3'd2, 4'd1,  5'd28, 1, 3'd3, 9'd59,  1, 0, 3'd5, 9'd59,  2, 0);
      run_vec("month12", 3'd1, 4'd12, 5'd0,  1, 3'd3, 9'd59,  1, 1, 3'd5, 9'd59,  1, 0);
      chk("hold_err", 32'(err0), 1);
      chk("hold_doy", 32'(doy0), 59);
      chk("hold_day", 32'(day1), 5);
      run_vec("anchor7", 3'd7, 4'd3,  5'd14, 0, 3'd6, 9'd104, 4, 0, 3'd0, 9'd105, 4, 0);
      run_vec("apr31",   3'd5, 4'd3,  5'd30, 1, 3'd6, 9'd104, 1, 1, 3'd0, 9'd105, 1, 0);
      run_vec("feb30",   3'd6, 4'd1,  5'd29, 1, 3'd6, 9'd104, 1, 1, 3'd0, 9'd105, 1, 0);
      run_vec("jul16",   3'd4, 4'd6,  5'd15, 0, 3'd4, 9'd196, 7, 0, 3'd5, 9'd197, 7, 0);
      run_vec("jun21",   3'd2, 4'd5,  5'd20, 0, 3'd5, 9'd171, 6, 0, 3'd6, 9'd172, 6, 1);

      // Reset four cycles into an October walk: no done, everything cleared.
      @(negedge clk);
      anchor_day = 3'd1; month = 4'd9; date = 5'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("walk_busy0", 32'(busy0), 1);
      chk("walk_busy1", 32'(busy1), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy0), 0);
      chk("abort_err", 32'(err0), 0);
      chk("abort_day", 32'(day0), 0);
      chk("abort_doy", 32'(doy0), 0);
      chk("abort_doy1", 32'(doy1), 0);
      run_vec("sep11",   3'd6, 4'd8,  5'd10, 0, 3'd0, 9'd253, 9, 0, 3'd1, 9'd254, 9, 0);

      repeat (20) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 0);
      chk("q1_drained", 32'(q1.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
